// File: rtl/tmu2dac_pkg.sv
// Shared types and constants for the tmu2dac serial DAC output path.
package tmu2dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int         DAC_FRAME_W = 16;
    localparam int         DAC_DATA_W  = 12;
    localparam logic [1:0] DAC_PD_BITS = 2'b00;
    localparam int         DAC_PAD_W   = 2;

    // Counter width for a modulo-n count, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK phase generator: CLK_DIV cycles high then CLK_DIV cycles low per bit,
// idling high outside SHIFT, with bit_start/bit_end strobes for the shifter.
module dac_sclk_gen
    import tmu2dac_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic shift,
    output logic sclk,
    output logic bit_start,
    output logic bit_end
);

    localparam int              PH_W    = cnt_width(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            half_q,  half_d;   // 0: high phase of a bit, 1: low phase
    logic            sclk_q,  sclk_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        phase_d   = '0;
        half_d    = 1'b0;
        bit_end   = shift && half_q && (phase_q == PH_LAST);
        bit_start = start || bit_end;
        if (shift && !start) begin
            if (phase_q == PH_LAST) begin
                half_d = ~half_q;
            end else begin
                phase_d = phase_q + PH_W'(1);
                half_d  = half_q;
            end
        end
        // The final low phase wraps half back to 0, so SCLK returns high with no extra case.
        sclk_d = ~half_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            half_q  <= 1'b0;
            sclk_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/tmu2dac.sv
// TMU/PID to serial 12-bit DAC converter: 16-bit SYNC/SCLK/DIN frames, MSB first.
// Build option TMU2DAC_OFFSET_EN: treat dac_data_in as two's complement and load offset binary.
module tmu2dac
    import tmu2dac_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tmu2dac_en,
    input  logic [DAC_DATA_W-1:0] dac_data_in,
    input  logic                  dac_data_valid,
    output logic                  dac_data_ready,
    output logic                  dac_sclk,
    output logic                  dac_sync_n,
    output logic                  dac_din,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int               GAP_W    = cnt_width(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_e                   state_q,   state_d;
    logic [DAC_FRAME_W-1:0]   shreg_q,   shreg_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
    logic                     sync_n_q,  sync_n_d;
    logic                     din_q,     din_d;
    logic                     done_q,    done_d;
    logic                     busy_q,    busy_d;

    logic                     accept;
    logic                     in_shift;
    logic                     bit_start;
    logic                     bit_end;
    logic [DAC_DATA_W-1:0]    word_load;

    always_comb begin
        word_load = dac_data_in;
`ifdef TMU2DAC_OFFSET_EN
        word_load[DAC_DATA_W-1] = ~dac_data_in[DAC_DATA_W-1];
`else
        word_load[DAC_DATA_W-1] = dac_data_in[DAC_DATA_W-1];
`endif
    end

    assign dac_data_ready = (state_q == ST_IDLE) && tmu2dac_en;
    assign accept         = dac_data_ready && dac_data_valid;
    assign in_shift       = (state_q == ST_SHIFT);

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .shift     (in_shift),
        .sclk      (dac_sclk),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d   = {DAC_PD_BITS, word_load, {DAC_PAD_W{1'b0}}};
                    bit_cnt_d = 4'd15;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_end) begin
                    shreg_d = {shreg_q[DAC_FRAME_W-2:0], 1'b0};
                    if (bit_cnt_q == 4'd0) begin
                        gap_cnt_d = GAP_LAST;
                        state_d   = ST_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from next-state values so the pins move on the same edge as the FSM.
        sync_n_d = (state_d != ST_SHIFT);
        busy_d   = (state_d != ST_IDLE);
        done_d   = in_shift && (state_d == ST_GAP);
        if (state_d != ST_SHIFT) begin
            din_d = 1'b0;
        end else if (bit_start) begin
            din_d = shreg_d[DAC_FRAME_W-1];
        end else begin
            din_d = din_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            // NOTE: the shift register is reset too, so an aborted frame leaves no stale data behind.
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sync_n_q  <= 1'b1;
            din_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sync_n_q  <= sync_n_d;
            din_q     <= din_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign dac_sync_n = sync_n_q;
    assign dac_din    = din_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tmu2dac.sv
// Randomized self-checking bench for tmu2dac: instance 0 uses default timing,
// instance 1 uses CLK_DIV=1/GAP_CYC=1; frames are decoded from the pins on SCLK falls.
module tb_tmu2dac;

    localparam int CD [2] = '{2, 1};
    localparam int GP [2] = '{4, 1};

    logic        clk;
    logic        rst;
    logic        en     [2];
    logic        valid  [2];
    logic [11:0] data   [2];
    logic        ready  [2];
    logic        sclk   [2];
    logic        sync_n [2];
    logic        din    [2];
    logic        done   [2];
    logic        busy   [2];

    int checks = 0;
    int errors = 0;

    tmu2dac u_dut0 (
        .clk (clk), .rst (rst), .tmu2dac_en (en[0]), .dac_data_in (data[0]),
        .dac_data_valid (valid[0]), .dac_data_ready (ready[0]), .dac_sclk (sclk[0]),
        .dac_sync_n (sync_n[0]), .dac_din (din[0]), .frame_done (done[0]), .busy (busy[0])
    );

    tmu2dac #(.CLK_DIV(1), .GAP_CYC(1)) u_dut1 (
        .clk (clk), .rst (rst), .tmu2dac_en (en[1]), .dac_data_in (data[1]),
        .dac_data_valid (valid[1]), .dac_data_ready (ready[1]), .dac_sclk (sclk[1]),
        .dac_sync_n (sync_n[1]), .dac_din (din[1]), .frame_done (done[1]), .busy (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: frame = power-down 00, 12-bit code, pad 00 -> code * 4.
    function automatic int model_frame(input int w);
        int code;
`ifdef TMU2DAC_OFFSET_EN
        code = (w + 2048) % 4096;
`else
        code = w;
`endif
        return code * 4;
    endfunction

    function automatic int model_latency(input int i);
        return 1 + 32 * CD[i] + GP[i];
    endfunction

    // Returns at the negedge where ready && valid is seen; the DUT accepts on the next posedge.
    task automatic wait_accept(input int i, output int ok, output int waited);
        ok = 0;
        waited = 0;
        for (int n = 0; n < 300; n++) begin
            if (ready[i] && valid[i]) begin
                ok = 1;
                return;
            end
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic capture(input int i, input logic nv, input logic [11:0] nd, input int en_drop,
                           output int frame, output int bits, output int lo, output int dn,
                           output int lat, output int viol);
        logic ps;
        ps = 1'b1;
        frame = 0; bits = 0; lo = 0; dn = 0; lat = -1; viol = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                valid[i] = nv;
                data[i]  = nd;
            end
            if (c == en_drop) en[i] = 1'b0;
            if (!sync_n[i]) lo++;
            if (ps && !sclk[i] && !sync_n[i]) begin
                frame = (frame << 1) | int'(din[i]);
                bits++;
            end
            ps = sclk[i];
            if (done[i]) dn++;
            if (!busy[i]) begin
                lat = c;
                break;
            end
            if (ready[i]) viol++;
        end
    endtask

    task automatic check_frame(input int i, input string tag, input int w, input int frame,
                               input int bits, input int lo, input int dn, input int lat,
                               input int viol);
        check({tag, " frame"},   frame, model_frame(w));
        check({tag, " bits"},    bits,  16);
        check({tag, " sync_lo"}, lo,    32 * CD[i]);
        check({tag, " done"},    dn,    1);
        check({tag, " latency"}, lat,   model_latency(i));
        check({tag, " busy_rdy"}, viol, 0);
    endtask

    task automatic send_and_check(input int i, input logic [11:0] w, input string tag);
        int ok, waited, f, b, lo, dn, lat, viol;
        data[i]  = w;
        valid[i] = 1'b1;
        wait_accept(i, ok, waited);
        check({tag, " accept"}, ok, 1);
        if (ok == 0) begin
            valid[i] = 1'b0;
            return;
        end
        capture(i, 1'b0, 12'h000, -1, f, b, lo, dn, lat, viol);
        check_frame(i, tag, int'(w), f, b, lo, dn, lat, viol);
    endtask

    initial begin
        int ok, waited, f, b, lo, dn, lat, viol, cnt;
        logic [11:0] w;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; valid[i] = 1'b0; data[i] = 12'h000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d sclk", i),   sclk[i],   1);
            check($sformatf("rst%0d sync_n", i), sync_n[i], 1);
            check($sformatf("rst%0d din", i),    din[i],    0);
            check($sformatf("rst%0d done", i),   done[i],   0);
            check($sformatf("rst%0d busy", i),   busy[i],   0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready en0", ready[0], 0);
        en[0] = 1'b1;
        en[1] = 1'b1;
        #1;
        check("ready en1", ready[0], 1);

        // Frame format.
        send_and_check(0, 12'hA5C, "fmt");

        // Valid held high across two words: second accept exactly one frame period later.
        data[0] = 12'h123; valid[0] = 1'b1;
        wait_accept(0, ok, waited);
        check("b2b accept1", ok, 1);
        capture(0, 1'b1, 12'hFFF, -1, f, b, lo, dn, lat, viol);
        check_frame(0, "b2b1", 'h123, f, b, lo, dn, lat, viol);
        check("b2b accept2", int'(ready[0] && valid[0]), 1);
        capture(0, 1'b0, 12'h000, -1, f, b, lo, dn, lat, viol);
        check_frame(0, "b2b2", 'hFFF, f, b, lo, dn, lat, viol);

        // Enable dropped mid-frame: frame completes, pending word waits for enable.
        data[0] = 12'h3C3; valid[0] = 1'b1;
        wait_accept(0, ok, waited);
        check("en accept", ok, 1);
        capture(0, 1'b1, 12'h0F0, 10, f, b, lo, dn, lat, viol);
        check_frame(0, "en", 'h3C3, f, b, lo, dn, lat, viol);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready[0] || busy[0]) cnt++;
        end
        check("en held off", cnt, 0);
        en[0] = 1'b1;
        #1;
        check("en ready back", ready[0], 1);
        wait_accept(0, ok, waited);
        check("en immediate accept", waited, 0);
        capture(0, 1'b0, 12'h000, -1, f, b, lo, dn, lat, viol);
        check_frame(0, "en_pend", 'h0F0, f, b, lo, dn, lat, viol);

        // Reset 20 cycles into a frame aborts it immediately.
        data[0] = 12'hFFF; valid[0] = 1'b1;
        wait_accept(0, ok, waited);
        check("rstmid accept", ok, 1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) valid[0] = 1'b0;
        end
        check("rstmid pre din", din[0], 1);
        check("rstmid pre sclk", sclk[0], 0);
        rst = 1'b1;
        #1;
        check("rstmid sync_n", sync_n[0], 1);
        check("rstmid sclk", sclk[0], 1);
        check("rstmid din", din[0], 0);
        check("rstmid busy", busy[0], 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[0]) cnt++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done[0]) cnt++;
        end
        check("rstmid no done", cnt, 0);
        check("rstmid ready", ready[0], 1);
        send_and_check(0, 12'h001, "post_rst");

        // Signed-range corners (expected value follows the build's data format).
        send_and_check(0, 12'h800, "c800");
        send_and_check(0, 12'h7FF, "c7ff");
        send_and_check(0, 12'h000, "c000");

        // Fast timing instance.
        send_and_check(1, 12'h555, "fast555");

        // Randomized words on both instances.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 6; n++) begin
                w = 12'($urandom_range(0, 4095));
                send_and_check(i, w, $sformatf("rnd%0d_%0d", i, n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
